// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, IMEM addressing and the IF/ID
// register with valid/ready handoff, redirect flush, halt and fault tracking.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [31:0]          imem_pc,
   input  logic [31:0]          imem_instruction,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   input  logic                 halt_req,
   output logic                 id_valid,
   input  logic                 id_ready,
   output logic [31:0]          id_instruction,
   output logic [31:0]          id_pc,
   output logic [31:0]          id_pc_plus4,
   output logic                 fetch_fault,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic        accept;
   logic        redirect;
   logic        load;

   assign imem_pc  = pc_q;
   assign pc_plus4 = pc_q + 32'd4;
   assign accept   = id_valid & id_ready;
   assign redirect = redirect_valid & (state_q != BOOT);
   assign load     = (state_q == RUN) & ~halt_req & ~redirect_valid
                   & (~id_valid | id_ready);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = halt_req ? HALTED : RUN;
         RUN:     if (halt_req) state_d = HALTED;
         HALTED:  if (!halt_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect wins over load and drain; a pending handshake still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         id_valid       <= 1'b0;
         id_instruction <= 32'h0;
         id_pc          <= 32'h0;
         id_pc_plus4    <= 32'h0;
      end else if (redirect) begin
         pc_q     <= {redirect_pc[31:2], 2'b00};
         id_valid <= 1'b0;
      end else if (load) begin
         pc_q           <= pc_plus4;
         id_valid       <= 1'b1;
         id_instruction <= imem_instruction;
         id_pc          <= pc_q;
         id_pc_plus4    <= pc_plus4;
      end else if (accept) begin
         id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_fault <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         fetch_fault <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (accept) begin
         fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage with a small combinational IMEM.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_pc;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int vectors;
   int miscompares;

   if_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .CNT_WIDTH(32)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_pc         (imem_pc),
      .imem_instruction(imem_instruction),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .halt_req        (halt_req),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_instruction  (id_instruction),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .fetch_fault     (fetch_fault),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program words at 0..C; any other address returns its own complement.
   always_comb begin
      case (imem_pc)
         32'h0:   imem_instruction = 32'h2009_0004;
         32'h4:   imem_instruction = 32'h200A_0004;
         32'h8:   imem_instruction = 32'h016A_5820;
         32'hC:   imem_instruction = 32'h112A_FFFE;
         default: imem_instruction = ~imem_pc;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      id_ready       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      id_ready       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({id_valid, fetch_fault, imem_pc, fetch_count} !== 66'h0) begin
         miscompares++;
         $display("FAIL reset_ctl got v=%b f=%b pc=%h cnt=%0d want 0",
                  id_valid, fetch_fault, imem_pc, fetch_count);
      end
      vectors++;
      if ({id_instruction, id_pc, id_pc_plus4} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h %h %h want 0",
                  id_instruction, id_pc, id_pc_plus4);
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if (id_valid !== 1'b0 || imem_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL boot_nofetch got v=%b pc=%h want v=0 pc=0",
                  id_valid, imem_pc);
      end
   endtask

   task automatic test_pipeline();
      logic [31:0] words [4];
      words[0] = 32'h2009_0004;
      words[1] = 32'h200A_0004;
      words[2] = 32'h016A_5820;
      words[3] = 32'h112A_FFFE;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)
             || id_instruction !== words[i]
             || id_pc_plus4 !== 32'(4 * i + 4)
             || fetch_count !== 32'(i)) begin
            miscompares++;
            $display("FAIL pipe%0d got v=%b pc=%h ins=%h p4=%h cnt=%0d want pc=%h ins=%h cnt=%0d",
                     i, id_valid, id_pc, id_instruction, id_pc_plus4,
                     fetch_count, 32'(4 * i), words[i], i);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (id_valid !== 1'b1 || id_pc !== 32'h4 || imem_pc !== 32'h8
             || id_instruction !== 32'h200A_0004 || fetch_count !== 32'd1) begin
            miscompares++;
            $display("FAIL stall%0d got v=%b pc=%h ipc=%h ins=%h cnt=%0d want pc=4 ipc=8 cnt=1",
                     i, id_valid, id_pc, imem_pc, id_instruction, fetch_count);
         end
      end
      id_ready = 1'b1;
      tick();
      vectors++;
      if (id_pc !== 32'h8 || id_valid !== 1'b1 || fetch_count !== 32'd2) begin
         miscompares++;
         $display("FAIL stall_release got pc=%h v=%b cnt=%0d want pc=8 v=1 cnt=2",
                  id_pc, id_valid, fetch_count);
      end
   endtask

   task automatic test_redirect();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8;
      tick();
      redirect_valid = 1'b0;
      vectors++;
      if (id_valid !== 1'b0 || imem_pc !== 32'h8 || fetch_count !== 32'd4) begin
         miscompares++;
         $display("FAIL redir_flush got v=%b ipc=%h cnt=%0d want v=0 ipc=8 cnt=4",
                  id_valid, imem_pc, fetch_count);
      end
      tick();
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8
          || id_instruction !== 32'h016A_5820) begin
         miscompares++;
         $display("FAIL redir_target got v=%b pc=%h ins=%h want v=1 pc=8 ins=016a5820",
                  id_valid, id_pc, id_instruction);
      end
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h6;
      tick();
      redirect_valid = 1'b0;
      vectors++;
      if (imem_pc !== 32'h4 || fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_set got ipc=%h f=%b v=%b want ipc=4 f=1 v=0",
                  imem_pc, fetch_fault, id_valid);
      end
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      tick();
      redirect_valid = 1'b0;
      tick();
      vectors++;
      if (fetch_fault !== 1'b1 || id_pc !== 32'h10) begin
         miscompares++;
         $display("FAIL fault_sticky got f=%b pc=%h want f=1 pc=10",
                  fetch_fault, id_pc);
      end
      do_reset();
      vectors++;
      if (fetch_fault !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_clear got %b want 0", fetch_fault);
      end
   endtask

   task automatic test_halt();
      tick();
      tick();
      halt_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (id_valid !== 1'b0 || imem_pc !== 32'h8 || fetch_count !== 32'd2) begin
            miscompares++;
            $display("FAIL halt%0d got v=%b ipc=%h cnt=%0d want v=0 ipc=8 cnt=2",
                     i, id_valid, imem_pc, fetch_count);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'hC;
      tick();
      redirect_valid = 1'b0;
      tick();
      vectors++;
      if (id_valid !== 1'b0 || imem_pc !== 32'hC) begin
         miscompares++;
         $display("FAIL halt_redir got v=%b ipc=%h want v=0 ipc=c",
                  id_valid, imem_pc);
      end
      halt_req = 1'b0;
      tick();
      tick();
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'hC
          || id_instruction !== 32'h112A_FFFE) begin
         miscompares++;
         $display("FAIL halt_resume got v=%b pc=%h ins=%h want v=1 pc=c ins=112afffe",
                  id_valid, id_pc, id_instruction);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      vectors++;
      if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0
          || id_instruction !== 32'h0000_0003) begin
         miscompares++;
         $display("FAIL wrap_top got pc=%h p4=%h ins=%h want fffffffc 0 3",
                  id_pc, id_pc_plus4, id_instruction);
      end
      tick();
      vectors++;
      if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4
          || id_instruction !== 32'h2009_0004) begin
         miscompares++;
         $display("FAIL wrap_zero got pc=%h p4=%h ins=%h want 0 4 20090004",
                  id_pc, id_pc_plus4, id_instruction);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({id_valid, fetch_fault, imem_pc, fetch_count,
           id_instruction, id_pc, id_pc_plus4} !== 162'h0) begin
         miscompares++;
         $display("FAIL async_reset got v=%b pc=%h ipc=%h cnt=%0d ins=%h want 0",
                  id_valid, id_pc, imem_pc, fetch_count, id_instruction);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      test_reset();
      test_pipeline();
      test_stall();
      test_redirect();
      test_fault();
      test_halt();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
